rr_resource_arbiter: RTL and testbench

// Round-robin arbiter that shares one resource among NUM_REQ requesters.
// - Grants are held across a multi-cycle transaction.
// - Each grant is released by the holder's done pulse, or by the holder dropping its req.
// - Sits in front of a shared resource (bus, memory port, datapath unit) and sequences access.
// - Fairness: no requester waits more than NUM_REQ-1 other grants.
//

---
 rtl/rr_resource_arbiter_if.sv | 22 ++
 rtl/rr_resource_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_resource_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between requesters (master) and rr_resource_arbiter (slave).
interface rr_resource_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned GNT_ID_W = 2
);
    logic [NUM_REQ-1:0]  req;
    logic                done;
    logic [NUM_REQ-1:0]  gnt;
    logic [GNT_ID_W-1:0] gnt_id;
    logic                busy;
    logic                timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, busy, timeout
    );
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter holding each grant until done or req drop, with one dead cycle per release.
// Optional grant watchdog enabled by defining RR_GRANT_TIMEOUT_EN.
module rr_resource_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned GNT_ID_W = 2,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_resource_arbiter_if.slave bus
);
    if (NUM_REQ < 2 || NUM_REQ > 16 || (2 ** GNT_ID_W) < NUM_REQ || MAX_HOLD < 2) begin : g_param_check
        $error("rr_resource_arbiter: illegal parameter combination");
    end

    localparam logic [GNT_ID_W-1:0] LAST_IDX = GNT_ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e              state_q;
    logic [GNT_ID_W-1:0] last_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [GNT_ID_W-1:0] gnt_id_q;
    logic                busy_q;

    logic                win_vld;
    logic [GNT_ID_W-1:0] win_id;
    logic [GNT_ID_W-1:0] cand;
    logic                release_hit;

    // Circular scan starting one past the last-served requester.
    always_comb begin
        win_vld = 1'b0;
        win_id  = last_q;
        cand    = last_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + GNT_ID_W'(1);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    assign release_hit = bus.done || !bus.req[gnt_id_q];

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= LAST_IDX;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        gnt_q    <= NUM_REQ'(1) << win_id;
                        gnt_id_q <= win_id;
                        busy_q   <= 1'b1;
                        hold_q   <= '0;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    // A normal release wins over a coincident watchdog expiry.
                    if (release_hit) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        last_q  <= gnt_id_q;
                        state_q <= IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        last_q    <= gnt_id_q;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.timeout = timeout_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= LAST_IDX;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        gnt_q    <= NUM_REQ'(1) << win_id;
                        gnt_id_q <= win_id;
                        busy_q   <= 1'b1;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_hit) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        last_q  <= gnt_id_q;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Scoreboard bench for rr_resource_arbiter: directed scenarios plus randomized request/done traffic.
module tb_rr_resource_arbiter;
    localparam int unsigned N        = 4;
    localparam int unsigned IDW      = 2;
    localparam int unsigned MAX_HOLD = 16;
`ifdef RR_GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_resource_arbiter_if #(.NUM_REQ(N), .GNT_ID_W(IDW)) bus ();

    rr_resource_arbiter #(
        .NUM_REQ (N),
        .GNT_ID_W(IDW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           busy;
        logic           to;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: who holds the resource, who was served last, how long it has been held.
    int m_holder = -1;
    int m_last   = N - 1;
    int m_held   = 0;

    task automatic chk(input string name, input int act, input int req_v);
        n_tests++;
        if (act != req_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_last   = N - 1;
        m_held   = 0;
    endtask

    // Applies one clock edge worth of rules to the model and queues the expected outputs.
    task automatic model_step(input logic [N-1:0] r, input logic d);
        exp_t e;
        logic to = 1'b0;
        if (m_holder >= 0) begin
            if (d || !r[m_holder]) begin
                m_last   = m_holder;
                m_holder = -1;
            end else if (TO_EN && m_held == MAX_HOLD - 1) begin
                m_last   = m_holder;
                m_holder = -1;
                to       = 1'b1;
            end else begin
                m_held++;
            end
        end else if (r != '0) begin
            for (int i = 1; i <= N; i++) begin
                int c = (m_last + i) % N;
                if (m_holder < 0 && r[c]) m_holder = c;
            end
            m_held = 0;
        end
        e.gnt  = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
        e.id   = (m_holder >= 0) ? IDW'(m_holder) : '0;
        e.busy = (m_holder >= 0);
        e.to   = to;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        model_step(r, d);
    endtask

    task automatic check_gnt_after_edge(input string name, input int g);
        @(posedge clk);
        #2;
        chk(name, int'(bus.gnt), g);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without an edge.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", int'(bus.gnt), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_id", int'(bus.gnt_id), 0);
        chk("async_rst_timeout", int'(bus.timeout), 0);
        model_reset();
        rst = 1'b0;
    endtask

    // Monitor: every post-reset edge yields one expected response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_gnt", int'(bus.gnt), int'(e.gnt));
                chk("sb_busy", int'(bus.busy), int'(e.busy));
                chk("sb_timeout", int'(bus.timeout), int'(e.to));
                chk("sb_onehot0", int'($onehot0(bus.gnt)), 1);
                if (e.busy) chk("sb_gnt_id", int'(bus.gnt_id), int'(e.id));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] r;
        logic         d;
        bus.req  = '0;
        bus.done = 1'b0;
        #3;
        chk("reset_gnt", int'(bus.gnt), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_id", int'(bus.gnt_id), 0);
        chk("reset_timeout", int'(bus.timeout), 0);
        #5;
        rst = 1'b0;

        // First grant after reset goes to requester 0.
        step(4'b1111, 1'b0);
        check_gnt_after_edge("first_grant", 1);

        // Full rotation with done pulsed on every grant.
        for (int k = 0; k < 12; k++) step(4'b1111, m_holder >= 0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        // Sparse wrap: serve 1, then 3 and 0 compete.
        mid_reset();
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b1001, 1'b0);
        check_gnt_after_edge("sparse_wrap_3", 8);
        step(4'b1001, 1'b1);
        step(4'b0001, 1'b0);
        check_gnt_after_edge("sparse_wrap_0", 1);
        step(4'b0001, 1'b1);

        // No preemption, then holder abandons.
        mid_reset();
        step(4'b0100, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0101, 1'b0);
        step(4'b0101, 1'b1);
        step(4'b0101, 1'b0);
        check_gnt_after_edge("after_nopreempt", 1);
        step(4'b0000, 1'b0);
        check_gnt_after_edge("holder_abandon", 0);

        // Reset mid-grant restores req[0]-first pointer.
        step(4'b0100, 1'b0);
        mid_reset();
        step(4'b0110, 1'b0);
        check_gnt_after_edge("post_rst_grant", 2);
        step(4'b0000, 1'b0);

        // Long hold without done.
        step(4'b0000, 1'b0);
        for (int k = 0; k < 120; k++) step(4'b0010, 1'b0);
        if (!TO_EN) begin
            @(posedge clk);
            #2;
            chk("long_hold_gnt", int'(bus.gnt), 2);
            chk("long_hold_timeout", int'(bus.timeout), 0);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // Random traffic; requesters mostly keep pending requests, holders occasionally abandon.
        r = '0;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N; i++) begin
                if (i == m_holder)  r[i] = ($urandom_range(15) != 0);
                else if (r[i])      r[i] = ($urandom_range(7) != 0);
                else                r[i] = ($urandom_range(3) == 0);
            end
            d = (m_holder >= 0) ? ($urandom_range(4) == 0) : ($urandom_range(7) == 0);
            step(r, d);
        end
        step('0, 1'b0);
        step('0, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
